// File: rtl/sys_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sys_bus_arbiter
//
// Shares the system bus between master 0 (CPU M stage) and master 1 (DMA).
// Round-robin arbitration, address decode, wait on the selected slave's ready
// and a timeout. Each transfer goes IDLE -> ACCESS -> RESP, or IDLE -> RESP on
// a decode error. The winner gets a one-cycle ack with err/rdata.
//
// Slave map (one-hot s_sel / s_ready order {IG,TC1,TC0,DM}):
//   DM  0x0000_0000-0x0000_2fff
//   TC0 0x0000_7f00-0x0000_7f0b
//   TC1 0x0000_7f10-0x0000_7f1b
//   IG  0x0000_7f20-0x0000_7f23
//
// Parameters:
//   TIMEOUT  ACCESS cycles without ready before an err response (>= 2)
//   CNT_W    width of the timeout counter (must hold TIMEOUT)
//
// Optional feature (compile-time macro ARB_LOCK_EN):
//   defined   -> a grant with mX_lock=1 keeps the bus owner for that master
//   undefined -> mX_lock is ignored, pure round-robin
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mX_req/addr/we/be/wdata     master request, held stable until ack
//   mX_lock                     lock request (ARB_LOCK_EN only)
//   mX_ack/err/rdata            registered one-cycle response to the winner
//   s_sel                       one-hot slave select, only during ACCESS
//   s_addr/s_we/s_be/s_wdata    access latched from the winner
//   s_ready                     per-slave ready
//   dm/tc0/tc1/ig_rdata         per-slave read data
// -----------------------------------------------------------------------------
module sys_bus_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  // master 0
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_wdata,
  input  logic        m0_lock,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  // master 1
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  // slave side
  output logic [3:0]  s_sel,
  output logic [31:0] s_addr,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_wdata,
  input  logic [3:0]  s_ready,
  input  logic [31:0] dm_rdata,
  input  logic [31:0] tc0_rdata,
  input  logic [31:0] tc1_rdata,
  input  logic [31:0] ig_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Address decode to a one-hot slave select; zero means no slave matched.
  function automatic logic [3:0] decode_sel(input logic [31:0] addr);
    logic [3:0] sel;
    if (addr <= 32'h0000_2fff) begin
      sel = 4'b0001;
    end else if (addr >= 32'h0000_7f00 && addr <= 32'h0000_7f0b) begin
      sel = 4'b0010;
    end else if (addr >= 32'h0000_7f10 && addr <= 32'h0000_7f1b) begin
      sel = 4'b0100;
    end else if (addr >= 32'h0000_7f20 && addr <= 32'h0000_7f23) begin
      sel = 4'b1000;
    end else begin
      sel = 4'b0000;
    end
    return sel;
  endfunction

  state_t            state_r;
  state_t            state_nxt_s;
  logic              rr_last_r;
  logic              winner_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [3:0]        sel_nxt_s;

  logic              gnt_valid_s;
  logic              gnt_id_s;
  logic [31:0]       w_addr_s;
  logic              w_we_s;
  logic [3:0]        w_be_s;
  logic [31:0]       w_wdata_s;
  logic              w_lock_s;
  logic [3:0]        dec_sel_s;
  logic              dec_err_s;
  logic              ready_hit_s;
  logic              timeout_s;
  logic [31:0]       sel_rdata_s;

  logic              latch_go_s;
  logic              resp_go_s;
  logic              resp_id_s;
  logic              resp_err_s;
  logic [31:0]       resp_rdata_s;

`ifdef ARB_LOCK_EN
  logic              lock_act_r;
  logic              lock_id_r;
`else
  logic              lock_unused_s;
  assign lock_unused_s = m0_lock ^ m1_lock ^ w_lock_s;
`endif

  // Arbitration: a lone requester wins; on a tie the master that did not win
  // last time wins, unless a lock owner is requesting.
  always_comb begin
    gnt_valid_s = m0_req | m1_req;
    if (m0_req && m1_req) begin
`ifdef ARB_LOCK_EN
      gnt_id_s = lock_act_r ? lock_id_r : ~rr_last_r;
`else
      gnt_id_s = ~rr_last_r;
`endif
    end else if (m1_req) begin
      gnt_id_s = 1'b1;
    end else begin
      gnt_id_s = 1'b0;
    end
  end

  // Mux the winning master's access onto the internal request path.
  always_comb begin
    if (gnt_id_s) begin
      w_addr_s  = m1_addr;
      w_we_s    = m1_we;
      w_be_s    = m1_be;
      w_wdata_s = m1_wdata;
      w_lock_s  = m1_lock;
    end else begin
      w_addr_s  = m0_addr;
      w_we_s    = m0_we;
      w_be_s    = m0_be;
      w_wdata_s = m0_wdata;
      w_lock_s  = m0_lock;
    end
  end

  // Decode of the winner's access; timer/IG registers only take full-word stores.
  always_comb begin
    dec_sel_s = decode_sel(w_addr_s);
    dec_err_s = (dec_sel_s == 4'b0000) ||
                (w_we_s && !dec_sel_s[0] && (w_be_s != 4'hf));
  end

  // Only the ready and read data of the selected slave matter.
  always_comb begin
    ready_hit_s = |(s_ready & s_sel);
    timeout_s   = (cnt_r == CNT_LAST);
    case (s_sel)
      4'b0001: sel_rdata_s = dm_rdata;
      4'b0010: sel_rdata_s = tc0_rdata;
      4'b0100: sel_rdata_s = tc1_rdata;
      4'b1000: sel_rdata_s = ig_rdata;
      default: sel_rdata_s = 32'h0000_0000;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state plus per-cycle control: grant latch, select, counter, response.
  always_comb begin
    state_nxt_s  = state_r;
    sel_nxt_s    = s_sel;
    cnt_nxt_s    = cnt_r;
    latch_go_s   = 1'b0;
    resp_go_s    = 1'b0;
    resp_id_s    = winner_r;
    resp_err_s   = 1'b0;
    resp_rdata_s = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (gnt_valid_s) begin
          latch_go_s = 1'b1;
          resp_id_s  = gnt_id_s;
          cnt_nxt_s  = {CNT_W{1'b0}};
          if (dec_err_s) begin
            sel_nxt_s   = 4'b0000;
            resp_go_s   = 1'b1;
            resp_err_s  = 1'b1;
            state_nxt_s = ST_RESP;
          end else begin
            sel_nxt_s   = dec_sel_s;
            state_nxt_s = ST_ACCESS;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (ready_hit_s) begin
          resp_go_s    = 1'b1;
          resp_rdata_s = s_we ? 32'h0000_0000 : sel_rdata_s;
          sel_nxt_s    = 4'b0000;
          state_nxt_s  = ST_RESP;
        end else if (timeout_s) begin
          resp_go_s   = 1'b1;
          resp_err_s  = 1'b1;
          sel_nxt_s   = 4'b0000;
          state_nxt_s = ST_RESP;
        end else begin
          // timeout_s is false here, so the counter never passes CNT_LAST
          cnt_nxt_s   = cnt_r + CNT_ONE;
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        sel_nxt_s   = 4'b0000;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping and the latched slave-side access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_r <= 1'b1;
      winner_r  <= 1'b0;
      cnt_r     <= {CNT_W{1'b0}};
      s_sel     <= 4'b0000;
      s_addr    <= 32'h0000_0000;
      s_we      <= 1'b0;
      s_be      <= 4'h0;
      s_wdata   <= 32'h0000_0000;
    end else begin
      cnt_r <= cnt_nxt_s;
      s_sel <= sel_nxt_s;
      if (latch_go_s) begin
        rr_last_r <= gnt_id_s;
        winner_r  <= gnt_id_s;
        s_addr    <= w_addr_s;
        s_we      <= w_we_s;
        s_be      <= w_be_s;
        s_wdata   <= w_wdata_s;
      end else begin
        rr_last_r <= rr_last_r;
        winner_r  <= winner_r;
        s_addr    <= s_addr;
        s_we      <= s_we;
        s_be      <= s_be;
        s_wdata   <= s_wdata;
      end
    end
  end

  // Registered response; only the winner sees ack/err/rdata, for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= 32'h0000_0000;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= 32'h0000_0000;
    end else if (resp_go_s) begin
      m0_ack   <= ~resp_id_s;
      m0_err   <= ~resp_id_s & resp_err_s;
      m0_rdata <= resp_id_s ? 32'h0000_0000 : resp_rdata_s;
      m1_ack   <= resp_id_s;
      m1_err   <= resp_id_s & resp_err_s;
      m1_rdata <= resp_id_s ? resp_rdata_s : 32'h0000_0000;
    end else begin
      m0_ack   <= 1'b0;
      m0_err   <= 1'b0;
      m0_rdata <= 32'h0000_0000;
      m1_ack   <= 1'b0;
      m1_err   <= 1'b0;
      m1_rdata <= 32'h0000_0000;
    end
  end

`ifdef ARB_LOCK_EN
  // Lock ownership: set by a locked grant, dropped by an unlocked grant or any err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_act_r <= 1'b0;
      lock_id_r  <= 1'b0;
    end else if (latch_go_s) begin
      if (dec_err_s || !w_lock_s) begin
        lock_act_r <= 1'b0;
        lock_id_r  <= lock_id_r;
      end else begin
        lock_act_r <= 1'b1;
        lock_id_r  <= gnt_id_s;
      end
    end else if (resp_go_s && resp_err_s) begin
      lock_act_r <= 1'b0;
      lock_id_r  <= lock_id_r;
    end else begin
      lock_act_r <= lock_act_r;
      lock_id_r  <= lock_id_r;
    end
  end
`endif

endmodule

// File: tb/tb_sys_bus_arbiter.sv
module tb_sys_bus_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m0_lock, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_be;
  logic        m1_req, m1_we, m1_lock, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_be;
  logic [3:0]  s_sel, s_be, s_ready;
  logic [31:0] s_addr, s_wdata;
  logic        s_we;
  logic [31:0] dm_rdata, tc0_rdata, tc1_rdata, ig_rdata;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  sys_bus_arbiter #(.TIMEOUT(TO), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_be(m0_be),
    .m0_wdata(m0_wdata), .m0_lock(m0_lock),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_be(m1_be),
    .m1_wdata(m1_wdata), .m1_lock(m1_lock),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_sel(s_sel), .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_ready(s_ready),
    .dm_rdata(dm_rdata), .tc0_rdata(tc0_rdata), .tc1_rdata(tc1_rdata), .ig_rdata(ig_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every ack is matched against the oldest expected response.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && (m0_ack || m1_ack)) begin
        total++;
        if (m0_ack && m1_ack) begin
          bad++;
          $display("FAIL both_ack: m0_ack=1 m1_ack=1, required only one");
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_ack: m0_ack=%0b m1_ack=%0b, required none", m0_ack, m1_ack);
        end else begin
          mon_e = exp_q.pop_front();
          if (m1_ack !== mon_e.id ||
              (m1_ack ? m1_err : m0_err) !== mon_e.err ||
              (m1_ack ? m1_rdata : m0_rdata) !== mon_e.rdata) begin
            bad++;
            $display("FAIL resp: got id=%0b err=%0b rdata=%h, required id=%0b err=%0b rdata=%h",
                     m1_ack, m1_ack ? m1_err : m0_err, m1_ack ? m1_rdata : m0_rdata,
                     mon_e.id, mon_e.err, mon_e.rdata);
          end
        end
      end
    end
  end

  function automatic void push(input logic id, input logic err, input logic [31:0] rdata);
    exp_t e;
    e.id = id; e.err = err; e.rdata = rdata;
    exp_q.push_back(e);
  endfunction

  task automatic idle_inputs();
    m0_req = 1'b0; m0_we = 1'b0; m0_lock = 1'b0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one request from master id and waits (bounded) for its ack.
  // lat counts negedges from request to ack; sel_or collects s_sel on the way.
  task automatic issue(input logic id, input logic [31:0] addr, input logic we,
                       input logic [3:0] be, input logic [31:0] wdata,
                       output int lat, output logic [3:0] sel_or);
    lat = 0;
    sel_or = 4'b0000;
    @(negedge clk);
    if (id) begin
      m1_addr = addr; m1_we = we; m1_be = be; m1_wdata = wdata; m1_req = 1'b1;
    end else begin
      m0_addr = addr; m0_we = we; m0_be = be; m0_wdata = wdata; m0_req = 1'b1;
    end
    do begin
      @(negedge clk);
      lat++;
      sel_or = sel_or | s_sel;
    end while (!(id ? m1_ack : m0_ack) && lat < 100);
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #13;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({s_sel, s_addr, s_we, s_be, s_wdata} !== 73'h0) begin
      bad++;
      $display("FAIL reset_bus: got sel=%b addr=%h we=%b be=%h wdata=%h, required all zero",
               s_sel, s_addr, s_we, s_be, s_wdata);
    end
    total++;
    if ({m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata} !== 68'h0) begin
      bad++;
      $display("FAIL reset_master: got m0 %b%b %h m1 %b%b %h, required all zero",
               m0_ack, m0_err, m0_rdata, m1_ack, m1_err, m1_rdata);
    end
  endtask

  task automatic test_dm_load();
    int lat; logic [3:0] so;
    dm_rdata = 32'hDEAD_BEEF;
    s_ready  = 4'hf;
    push(1'b0, 1'b0, 32'hDEAD_BEEF);
    issue(1'b0, 32'h0000_1004, 1'b0, 4'hf, 32'h0, lat, so);
    total++;
    if (lat !== 2) begin bad++; $display("FAIL dm_load_lat: got %0d, required 2", lat); end
    total++;
    if (so !== 4'b0001) begin bad++; $display("FAIL dm_load_sel: got %b, required 0001", so); end
  endtask

  // Table of single accesses across decode boundaries.
  task automatic test_decode();
    logic [31:0] addrs [6] = '{32'h0000_2ffc, 32'h0000_3000, 32'h0000_7f0c,
                               32'h0000_7f1b, 32'h0000_7f24, 32'h0000_7f08};
    logic [3:0]  sels  [6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0010};
    logic [31:0] rds   [6] = '{32'h1111_0000, 32'h0, 32'h0, 32'h3333_0000, 32'h0, 32'h2222_0000};
    int lat; logic [3:0] so;
    dm_rdata = 32'h1111_0000; tc0_rdata = 32'h2222_0000;
    tc1_rdata = 32'h3333_0000; ig_rdata = 32'h4444_0000;
    s_ready = 4'hf;
    for (int i = 0; i < 6; i++) begin
      push(1'b1, (sels[i] == 4'b0000), rds[i]);
      issue(1'b1, addrs[i], 1'b0, 4'hf, 32'h0, lat, so);
      total++;
      if (so !== sels[i] || lat !== ((sels[i] == 4'b0000) ? 1 : 2)) begin
        bad++;
        $display("FAIL decode_%0d: got sel=%b lat=%0d, required sel=%b lat=%0d",
                 i, so, lat, sels[i], (sels[i] == 4'b0000) ? 1 : 2);
      end
    end
  endtask

  task automatic test_store();
    int lat; logic [3:0] so;
    s_ready = 4'hf;
    push(1'b0, 1'b1, 32'h0);
    issue(1'b0, 32'h0000_7f04, 1'b1, 4'b0011, 32'hAAAA_5555, lat, so);
    total++;
    if (lat !== 1 || so !== 4'b0000) begin
      bad++; $display("FAIL store_partial_tc0: got lat=%0d sel=%b, required lat=1 sel=0000", lat, so);
    end
    push(1'b0, 1'b0, 32'h0);
    issue(1'b0, 32'h0000_7f04, 1'b1, 4'hf, 32'h1234_5678, lat, so);
    total++;
    if (lat !== 2 || so !== 4'b0010 || s_we !== 1'b1 || s_wdata !== 32'h1234_5678 ||
        s_addr !== 32'h0000_7f04) begin
      bad++;
      $display("FAIL store_full_tc0: got lat=%0d sel=%b we=%b wdata=%h addr=%h, required 2 0010 1 12345678 00007f04",
               lat, so, s_we, s_wdata, s_addr);
    end
    push(1'b1, 1'b0, 32'h0);
    issue(1'b1, 32'h0000_0040, 1'b1, 4'b0011, 32'h0, lat, so);
    total++;
    if (lat !== 2 || so !== 4'b0001 || s_be !== 4'b0011) begin
      bad++; $display("FAIL store_partial_dm: got lat=%0d sel=%b be=%b, required 2 0001 0011", lat, so, s_be);
    end
  endtask

  task automatic test_timeout();
    int lat; logic [3:0] so;
    s_ready = 4'b0111;
    push(1'b0, 1'b1, 32'h0);
    issue(1'b0, 32'h0000_7f20, 1'b0, 4'hf, 32'h0, lat, so);
    total++;
    if (lat !== TO + 1) begin bad++; $display("FAIL timeout_lat: got %0d, required %0d", lat, TO + 1); end
    total++;
    if (so !== 4'b1000 || s_sel !== 4'b0000) begin
      bad++; $display("FAIL timeout_sel: got seen=%b at_ack=%b, required 1000 0000", so, s_sel);
    end
    s_ready = 4'hf;
  endtask

  task automatic test_back_to_back();
    int n, lim, last_c, gap;
    apply_reset();
    dm_rdata = 32'hA0A0_0001; tc1_rdata = 32'hB0B0_0002; s_ready = 4'hf;
    for (int i = 0; i < 5; i++) push(i[0], 1'b0, i[0] ? 32'hB0B0_0002 : 32'hA0A0_0001);
    @(negedge clk);
    m0_addr = 32'h0000_0100; m0_we = 1'b0; m0_req = 1'b1;
    m1_addr = 32'h0000_7f14; m1_we = 1'b0; m1_req = 1'b1;
    n = 0; lim = 0; last_c = 0; gap = 3;
    while (n < 5 && lim < 200) begin
      @(negedge clk);
      lim++;
      if (m0_ack || m1_ack) begin
        if (n > 0 && cyc - last_c != 3) gap = cyc - last_c;
        last_c = cyc;
        n++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    total++;
    if (n !== 5) begin bad++; $display("FAIL b2b_count: got %0d acks, required 5", n); end
    total++;
    if (gap !== 3) begin bad++; $display("FAIL b2b_gap: got %0d cycles, required 3", gap); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    s_ready = 4'h0;
    @(negedge clk);
    m0_addr = 32'h0000_0010; m0_we = 1'b0; m0_req = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (s_sel !== 4'b0001) begin bad++; $display("FAIL midrst_pre: got sel=%b, required 0001", s_sel); end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (s_sel !== 4'b0000 || m0_ack !== 1'b0) begin
      bad++; $display("FAIL midrst: got sel=%b ack=%b, required 0000 0", s_sel, m0_ack);
    end
    m0_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    s_ready = 4'hf;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_lock();
    int n, c0, lim;
    apply_reset();
    dm_rdata = 32'hC0C0_0000; tc0_rdata = 32'hD0D0_0000; s_ready = 4'hf;
`ifdef ARB_LOCK_EN
    push(1'b0, 1'b0, 32'hC0C0_0000); push(1'b0, 1'b0, 32'hC0C0_0000); push(1'b1, 1'b0, 32'hD0D0_0000);
`else
    push(1'b0, 1'b0, 32'hC0C0_0000); push(1'b1, 1'b0, 32'hD0D0_0000); push(1'b0, 1'b0, 32'hC0C0_0000);
`endif
    @(negedge clk);
    m0_addr = 32'h0000_0200; m0_lock = 1'b1; m0_req = 1'b1;
    m1_addr = 32'h0000_7f00; m1_req = 1'b1;
    n = 0; c0 = 0; lim = 0;
    while (n < 3 && lim < 200) begin
      @(negedge clk);
      lim++;
      if (m0_ack || m1_ack) n++;
      if (m0_ack) begin
        c0++;
        if (c0 == 2) m0_req = 1'b0;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0;
    total++;
    if (n !== 3) begin bad++; $display("FAIL lock_count: got %0d acks, required 3", n); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    s_ready = 4'hf;
    dm_rdata = 32'h0; tc0_rdata = 32'h0; tc1_rdata = 32'h0; ig_rdata = 32'h0;
    test_reset();
    test_dm_load();
    test_decode();
    test_store();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_lock();
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL missing_acks: got %0d outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
